// File: rtl/survivor_wr_ctrl.sv
// Survivor-memory write controller: registers ACS decisions into an 8-row circular window and launches traceback.
// Latency: one cycle from accept to row write; tb_start one cycle after the final write.
// Backpressure: dec_ready is decoded from state only, low outside FILL; upstream holds data while it is low.
module survivor_wr_ctrl #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [DEC_W-1:0] dec_in,
    output logic             dec_ready,
    input  logic             flush,
    output logic [2:0]       wr_addr,
    output logic             wr_en,
    output logic [DEC_W-1:0] wr_data,
    output logic             tb_start,
    output logic [2:0]       tb_base,
    output logic [3:0]       tb_len,
    input  logic             tb_done,
    output logic [3:0]       fill_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        COMMIT = 3'd2,
        LAUNCH = 3'd3,
        TRACE  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wr_ptr;
    logic       accept;
    logic       full_hit;
    logic       flush_hit;
    logic       go_commit;

    assign accept    = dec_valid && dec_ready;
    assign full_hit  = accept && (fill_cnt == 4'd7);
    // A flush with nothing stored and nothing arriving has no window to trace.
    assign flush_hit = flush && ((fill_cnt != 4'd0) || accept);
    assign go_commit = (state == FILL) && (full_hit || flush_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FILL;
            FILL:    if (go_commit) state_nxt = COMMIT;
            COMMIT:  state_nxt = LAUNCH;
            LAUNCH:  state_nxt = TRACE;
            TRACE:   if (tb_done) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dec_ready = (state == FILL);
        tb_start  = (state == LAUNCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 3'd0;
            wr_addr  <= 3'd0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            tb_base  <= 3'd0;
            tb_len   <= 4'd0;
            fill_cnt <= 4'd0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= wr_ptr;
                wr_data <= dec_in;
                wr_ptr  <= wr_ptr + 3'd1;
            end
            // Newest entry is the one being written now, or the previous one on a bare flush.
            if (go_commit) begin
                tb_base <= accept ? wr_ptr : (wr_ptr - 3'd1);
                tb_len  <= fill_cnt + {3'd0, accept};
            end
            if ((state == TRACE) && tb_done) begin
                fill_cnt <= 4'd0;
            end else if (accept) begin
                fill_cnt <= fill_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_survivor_wr_ctrl.sv
// Directed bench for survivor_wr_ctrl with immediate-assertion checks.
module tb_survivor_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [3:0] dec_in;
    logic       dec_ready;
    logic       flush;
    logic [2:0] wr_addr;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       tb_start;
    logic [2:0] tb_base;
    logic [3:0] tb_len;
    logic       tb_done;
    logic [3:0] fill_cnt;

    int checks   = 0;
    int failures = 0;

    survivor_wr_ctrl #(.DEC_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .dec_valid(dec_valid),
        .dec_in   (dec_in),
        .dec_ready(dec_ready),
        .flush    (flush),
        .wr_addr  (wr_addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tb_start (tb_start),
        .tb_base  (tb_base),
        .tb_len   (tb_len),
        .tb_done  (tb_done),
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
        chk({tag, "_tb_start"},  32'(tb_start),  32'd0);
        chk({tag, "_tb_base"},   32'(tb_base),   32'd0);
        chk({tag, "_tb_len"},    32'(tb_len),    32'd0);
        chk({tag, "_fill_cnt"},  32'(fill_cnt),  32'd0);
        chk({tag, "_dec_ready"}, 32'(dec_ready), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        dec_valid = 1'b0;
        dec_in    = 4'd0;
        flush     = 1'b0;
        tb_done   = 1'b0;
        #2;
        chk_reset_vals("rst0");
        repeat (2) tick();
        rst = 1'b0;
        chk("idle_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("fill_ready", 32'(dec_ready), 32'd1);

        // Eight back-to-back vectors fill the window.
        dec_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dec_in = 4'(i + 1);
            tick();
            chk("full_wr_en",   32'(wr_en),    32'd1);
            chk("full_wr_addr", 32'(wr_addr),  32'(i));
            chk("full_wr_data", 32'(wr_data),  32'(i + 1));
            chk("full_tbstart", 32'(tb_start), 32'd0);
            chk("full_ready",   32'(dec_ready), (i < 7) ? 32'd1 : 32'd0);
        end
        dec_valid = 1'b0;
        chk("full_fill8", 32'(fill_cnt), 32'd8);
        tick();
        chk("full_launch", 32'(tb_start), 32'd1);
        chk("full_wr_en0", 32'(wr_en),    32'd0);
        chk("full_base",   32'(tb_base),  32'd7);
        chk("full_len",    32'(tb_len),   32'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_trace_start", 32'(tb_start), 32'd0);
            chk("full_trace_wr",    32'(wr_en),    32'd0);
        end
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        chk("done1_ready", 32'(dec_ready), 32'd1);
        chk("done1_fill",  32'(fill_cnt),  32'd0);
        chk("done1_base",  32'(tb_base),   32'd7);

        // Three vectors, flush with the third; pointer has wrapped to 0.
        dec_valid = 1'b1;
        dec_in = 4'hA; tick();
        chk("w3_addr0", 32'(wr_addr), 32'd0);
        chk("w3_data0", 32'(wr_data), 32'hA);
        dec_in = 4'hB; tick();
        chk("w3_addr1", 32'(wr_addr), 32'd1);
        dec_in = 4'hC; flush = 1'b1; tick();
        chk("w3_addr2", 32'(wr_addr), 32'd2);
        chk("w3_data2", 32'(wr_data), 32'hC);
        chk("w3_wr_en", 32'(wr_en),   32'd1);
        chk("w3_ready", 32'(dec_ready), 32'd0);
        dec_valid = 1'b0; flush = 1'b0;
        tick();
        chk("w3_start", 32'(tb_start), 32'd1);
        chk("w3_base",  32'(tb_base),  32'd2);
        chk("w3_len",   32'(tb_len),   32'd3);
        tick();
        tb_done = 1'b1; tick(); tb_done = 1'b0;

        // Flush on an empty window is ignored.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("eflush_ready", 32'(dec_ready), 32'd1);
        chk("eflush_start", 32'(tb_start),  32'd0);
        chk("eflush_wr",    32'(wr_en),     32'd0);
        tick();
        chk("eflush_ready2", 32'(dec_ready), 32'd1);
        chk("eflush_start2", 32'(tb_start),  32'd0);

        // Single vector with flush, then hold valid through TRACE.
        dec_valid = 1'b1; dec_in = 4'h5; flush = 1'b1; tick();
        dec_valid = 1'b0; flush = 1'b0;
        chk("one_addr", 32'(wr_addr), 32'd3);
        tick();
        chk("one_start", 32'(tb_start), 32'd1);
        chk("one_base",  32'(tb_base),  32'd3);
        chk("one_len",   32'(tb_len),   32'd1);
        tick();
        dec_valid = 1'b1; dec_in = 4'hE;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_wr",    32'(wr_en),     32'd0);
            chk("hold_ready", 32'(dec_ready), 32'd0);
        end
        tb_done = 1'b1; tick(); tb_done = 1'b0;
        chk("hold_fill_ready", 32'(dec_ready), 32'd1);
        chk("hold_fill_wr",    32'(wr_en),     32'd0);
        tick();
        dec_valid = 1'b0;
        chk("hold_acc_wr",   32'(wr_en),   32'd1);
        chk("hold_acc_addr", 32'(wr_addr), 32'd4);
        chk("hold_acc_data", 32'(wr_data), 32'hE);

        // Bare flush closes the one-entry window.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("bflush_wr",    32'(wr_en),     32'd0);
        chk("bflush_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("bflush_start", 32'(tb_start), 32'd1);
        chk("bflush_base",  32'(tb_base),  32'd4);
        chk("bflush_len",   32'(tb_len),   32'd1);
        tick();
        tb_done = 1'b1; tick(); tb_done = 1'b0;

        // Gapped input: five vectors at addresses 5,6,7,0,1.
        for (int i = 0; i < 5; i++) begin
            dec_valid = 1'b1; dec_in = 4'(i + 6); tick();
            dec_valid = 1'b0;
            chk("gap_wr",   32'(wr_en),   32'd1);
            chk("gap_addr", 32'(wr_addr), 32'((5 + i) % 8));
            chk("gap_data", 32'(wr_data), 32'(i + 6));
            tick();
            chk("gap_idle_wr",   32'(wr_en),   32'd0);
            chk("gap_hold_addr", 32'(wr_addr), 32'((5 + i) % 8));
        end
        chk("gap_fill", 32'(fill_cnt), 32'd5);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("gap_commit_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("gap_start", 32'(tb_start), 32'd1);
        chk("gap_base",  32'(tb_base),  32'd1);
        chk("gap_len",   32'(tb_len),   32'd5);
        tick();

        // Reset in TRACE.
        rst = 1'b1; #1;
        chk_reset_vals("rst_trace");
        tick();
        rst = 1'b0;
        chk("rst_trace_idle", 32'(dec_ready), 32'd0);
        tick();
        chk("rst_trace_fill", 32'(dec_ready), 32'd1);

        // Reset mid-FILL with four entries and a write in flight.
        dec_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dec_in = 4'(i + 1); tick();
            chk("mf_addr", 32'(wr_addr), 32'(i));
        end
        chk("mf_fill4", 32'(fill_cnt), 32'd4);
        dec_in = 4'h5;
        rst = 1'b1; #1;
        dec_valid = 1'b0;
        chk_reset_vals("rst_fill");
        tick();
        rst = 1'b0;
        chk("rst_fill_idle",  32'(dec_ready), 32'd0);
        chk("rst_fill_start", 32'(tb_start),  32'd0);
        tick();
        chk("rst_fill_ready", 32'(dec_ready), 32'd1);
        dec_valid = 1'b1; dec_in = 4'h7; tick();
        dec_valid = 1'b0;
        chk("post_rst_wr",   32'(wr_en),   32'd1);
        chk("post_rst_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_data", 32'(wr_data), 32'h7);
        chk("post_rst_fill", 32'(fill_cnt), 32'd1);
        tick();
        chk("post_rst_start", 32'(tb_start), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/survivor_wr_ctrl.md
Name: survivor_wr_ctrl

Overview:
- Write-side controller for the Viterbi survivor-path memory. It sits directly upstream of the 3-to-8 row-select decoder.
- Accepts per-stage ACS decision vectors over a valid/ready handshake and produces the 3-bit row address, the write-enable (the decoder's `choose`) and the registered write data.
- Launches a traceback once the 8-entry window is full or a frame flush is requested, then stalls the ACS until traceback completes.

Parameters:
- DEC_W, 4, decision bits per trellis stage (one per state); width of dec_in / wr_data.
- Memory depth is fixed at 8 entries (3-bit address, matches the decoder) and is not a parameter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- dec_valid  input  1  decision vector on dec_in is valid
- dec_in  input  DEC_W  ACS decision vector for one stage
- dec_ready  output  1  controller can accept a vector this cycle
- flush  input  1  end of frame; trace back whatever is stored
- wr_addr  output  3  survivor row address (decoder in)
- wr_en  output  1  row write strobe (decoder choose)
- wr_data  output  DEC_W  data for the addressed row
- tb_start  output  1  one-cycle traceback launch pulse
- tb_base  output  3  address of the newest stored entry
- tb_len  output  4  number of valid entries, 1..8
- tb_done  input  1  traceback unit finished
- fill_cnt  output  4  entries written in the current window, 0..8

Behaviour:
- Reset is asynchronous, active-high, on rst; single clock clk.
- Reset values:
  - state = IDLE; write pointer wr_ptr = 0.
  - wr_addr = 0, wr_en = 0, wr_data = 0.
  - tb_start = 0, tb_base = 0, tb_len = 0, fill_cnt = 0.
  - dec_ready = 0.
- States:
  - IDLE: always goes to FILL on the next edge. dec_ready = 0.
  - FILL: dec_ready = 1. Accept occurs when dec_valid && dec_ready at a rising edge.
  - COMMIT: last write in flight. dec_ready = 0. Always goes to LAUNCH.
  - LAUNCH: tb_start = 1 for exactly this cycle. dec_ready = 0. Always goes to TRACE.
  - TRACE: dec_ready = 0. Goes to FILL on tb_done.
- dec_ready is decoded from the state register; it has no combinational path from dec_valid.
- On each accept:
  - Next cycle, wr_en = 1, wr_addr = wr_ptr, wr_data = dec_in. Latency is one cycle.
  - wr_ptr increments modulo 8 (7 -> 0 wrap).
  - fill_cnt increments.
- wr_en is 0 in every cycle not immediately following an accept. wr_addr and wr_data hold their last values while wr_en = 0.
- Leaving FILL for COMMIT happens on an edge where:
  - an accept brings fill_cnt to 8, or
  - flush = 1 and (fill_cnt > 0 or an accept occurs on the same edge).
- On that edge:
  - tb_base = address of the entry just written.
  - tb_len = the post-increment fill_cnt.
- Ordering: the final wr_en occurs in COMMIT, and tb_start follows in the next cycle. Traceback never reads a row in the same cycle it is written.
- Simultaneous flush and accept: the accepted vector is stored and counted, then traceback launches.
- flush with fill_cnt = 0 and no accept: ignored, and the controller stays in FILL.
- flush in IDLE, COMMIT, LAUNCH or TRACE: ignored and not remembered.
- tb_done is honoured only in TRACE; it is ignored in all other states.
- On tb_done in TRACE:
  - fill_cnt clears to 0.
  - wr_ptr is not reset; the new window continues circularly.
  - tb_base and tb_len hold their values.
- dec_valid while dec_ready = 0: no effect. The upstream stage must hold its data.
- rst asserted mid-operation (any state, including TRACE):
  - Immediate return to reset values.
  - Any in-flight write strobe is dropped.
  - No tb_start is issued.

Test Plan:
- Reset then 8 back-to-back vectors 0x1..0x8 with dec_valid held high:
  - wr_en high for 8 consecutive cycles, wr_addr 0..7, wr_data 0x1..0x8.
  - dec_ready drops after the 8th accept.
  - tb_start is a single pulse one cycle after the last wr_en, with tb_base = 7 and tb_len = 8.
  - No further writes until tb_done.
- After the first traceback, pulse tb_done, then send 3 vectors and flush alongside the 3rd:
  - writes go to addresses 0, 1, 2 (pointer wrapped from 7).
  - tb_start follows with tb_base = 2 and tb_len = 3.
- flush asserted in FILL with fill_cnt = 0 and dec_valid = 0:
  - no tb_start, state stays FILL.
  - dec_ready remains 1.
- dec_valid held high in TRACE for 10 cycles, then tb_done:
  - zero writes during TRACE, dec_ready = 0 throughout.
  - The held vector is accepted on the first FILL cycle.
- Gapped input (valid every other cycle) for 5 vectors, then flush alone:
  - 5 writes, each one cycle after its accept.
  - tb_len = 5, tb_base = address of the 5th write.
- rst pulsed while in TRACE, then mid-FILL with fill_cnt = 4:
  - all outputs return to reset values asynchronously.
  - IDLE lasts one cycle before FILL.
  - The next write goes to wr_addr = 0.
